// File: rtl/fifo_sram_pkg.sv
// Shared definitions for the FIFO -> SRAM -> FIFO loopback engine.
// Holds the controller state encoding, the CSR register map and the data width.
package fifo_sram_pkg;

    localparam int DATA_W = 32;

    // Altera-style FIFO CSR register 0 returns the current fill level.
    localparam logic [2:0] CSR_FILL_LEVEL = 3'd0;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_IN_POLL    = 4'd1,
        S_IN_PWAIT   = 4'd2,
        S_IN_RD      = 4'd3,
        S_IN_RWAIT   = 4'd4,
        S_SRAM_WR    = 4'd5,
        S_OUT_POLL   = 4'd6,
        S_OUT_PWAIT  = 4'd7,
        S_SRAM_RD    = 4'd8,
        S_SRAM_RWAIT = 4'd9,
        S_OUT_PUSH   = 4'd10,
        S_FINISH     = 4'd11
    } state_t;

endpackage

// File: rtl/fifo_sram_loopback.sv
// Moves len words from the HPS-to-FPGA FIFO into SRAM, then drains the SRAM
// into the FPGA-to-HPS FIFO in the same order, XOR-ing every stored word.
module fifo_sram_loopback
    import fifo_sram_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int OUT_FIFO_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,

    output logic [2:0]        in_csr_address,
    output logic              in_csr_read,
    input  logic [DATA_W-1:0] in_csr_readdata,
    output logic              in_read,
    input  logic [DATA_W-1:0] in_readdata,

    output logic [2:0]        out_csr_address,
    output logic              out_csr_read,
    input  logic [DATA_W-1:0] out_csr_readdata,
    output logic              out_write,
    output logic [DATA_W-1:0] out_writedata,

    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_clken,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [DATA_W-1:0] sram_writedata,
    output logic [3:0]        sram_byteenable,
    input  logic [DATA_W-1:0] sram_readdata
);

    localparam int CW = ADDR_W + 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   idx, idx_nxt, idx_inc;
    logic [CW-1:0]   rem;
    logic [CW-1:0]   avail, avail_nxt;
    logic [31:0]     space, space_nxt;
    logic            last;
    logic            wr_nxt, rd_nxt;

    assign in_csr_address  = CSR_FILL_LEVEL;
    assign out_csr_address = CSR_FILL_LEVEL;

    assign rem     = len_q - idx;
    assign idx_inc = idx + CW'(1);
    assign last    = (idx_inc == len_q);

    // Clamp both fill-derived counts so a burst never overruns the transfer or the FIFO.
    assign avail_nxt = (in_csr_readdata < DATA_W'(rem)) ? in_csr_readdata[CW-1:0] : rem;
    assign space_nxt = (out_csr_readdata >= 32'(OUT_FIFO_DEPTH)) ? 32'd0
                     : 32'(OUT_FIFO_DEPTH) - out_csr_readdata;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
                    state_nxt = (len == '0) ? S_FINISH : S_IN_POLL;
                end
            end
            S_IN_POLL:  state_nxt = S_IN_PWAIT;
            S_IN_PWAIT: state_nxt = (avail_nxt == '0) ? S_IN_POLL : S_IN_RD;
            S_IN_RD:    state_nxt = S_IN_RWAIT;
            S_IN_RWAIT: state_nxt = S_SRAM_WR;
            S_SRAM_WR: begin
                if (last) begin
                    idx_nxt   = '0;
                    state_nxt = S_OUT_POLL;
                end else begin
                    idx_nxt   = idx_inc;
                    state_nxt = (avail > CW'(1)) ? S_IN_RD : S_IN_POLL;
                end
            end
            S_OUT_POLL:   state_nxt = S_OUT_PWAIT;
            S_OUT_PWAIT:  state_nxt = (space_nxt == 32'd0) ? S_OUT_POLL : S_SRAM_RD;
            S_SRAM_RD:    state_nxt = S_SRAM_RWAIT;
            S_SRAM_RWAIT: state_nxt = S_OUT_PUSH;
            S_OUT_PUSH: begin
                idx_nxt = idx_inc;
                if (last)                state_nxt = S_FINISH;
                else if (space > 32'd1)  state_nxt = S_SRAM_RD;
                else                     state_nxt = S_OUT_POLL;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign wr_nxt = (state_nxt == S_SRAM_WR);
    assign rd_nxt = (state_nxt == S_SRAM_RD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            len_q           <= '0;
            idx             <= '0;
            avail           <= '0;
            space           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            checksum        <= '0;
            in_csr_read     <= 1'b0;
            in_read         <= 1'b0;
            out_csr_read    <= 1'b0;
            out_write       <= 1'b0;
            out_writedata   <= '0;
            sram_address    <= '0;
            sram_clken      <= 1'b0;
            sram_chipselect <= 1'b0;
            sram_write      <= 1'b0;
            sram_writedata  <= '0;
            sram_byteenable <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            done  <= 1'b0;

            // Strobes are registered from the next state so each one is high
            // exactly while the FSM sits in the matching state.
            in_csr_read     <= (state_nxt == S_IN_POLL);
            in_read         <= (state_nxt == S_IN_RD);
            out_csr_read    <= (state_nxt == S_OUT_POLL);
            out_write       <= (state_nxt == S_OUT_PUSH);
            sram_chipselect <= wr_nxt | rd_nxt;
            sram_clken      <= wr_nxt | rd_nxt;
            sram_write      <= wr_nxt;
            sram_byteenable <= wr_nxt ? 4'hF : 4'h0;
            sram_address    <= (wr_nxt | rd_nxt) ? idx_nxt[ADDR_W-1:0] : '0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        checksum <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_IN_PWAIT:   avail          <= avail_nxt;
                S_IN_RWAIT:   sram_writedata <= in_readdata;
                S_SRAM_WR: begin
                    checksum <= checksum ^ sram_writedata;
                    avail    <= avail - CW'(1);
                end
                S_OUT_PWAIT:  space          <= space_nxt;
                S_SRAM_RWAIT: out_writedata  <= sram_readdata;
                S_OUT_PUSH:   space          <= space - 32'd1;
                S_FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_sram_loopback.sv
// Randomized loopback bench: behavioural FIFO/SRAM slaves and a word-list reference.
module tb_fifo_sram_loopback;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  len = '0;
    logic        busy, done;
    logic [31:0] checksum;
    logic [2:0]  in_csr_address, out_csr_address;
    logic        in_csr_read, in_read, out_csr_read, out_write;
    logic [31:0] in_csr_readdata = '0, in_readdata = '0, out_csr_readdata = '0;
    logic [31:0] out_writedata;
    logic [7:0]  sram_address;
    logic        sram_clken, sram_chipselect, sram_write;
    logic [31:0] sram_writedata;
    logic [3:0]  sram_byteenable;
    logic [31:0] sram_readdata = '0;

    fifo_sram_loopback #(.ADDR_W(8), .OUT_FIFO_DEPTH(256)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .busy(busy), .done(done), .checksum(checksum),
        .in_csr_address(in_csr_address), .in_csr_read(in_csr_read),
        .in_csr_readdata(in_csr_readdata), .in_read(in_read), .in_readdata(in_readdata),
        .out_csr_address(out_csr_address), .out_csr_read(out_csr_read),
        .out_csr_readdata(out_csr_readdata), .out_write(out_write), .out_writedata(out_writedata),
        .sram_address(sram_address), .sram_clken(sram_clken), .sram_chipselect(sram_chipselect),
        .sram_write(sram_write), .sram_writedata(sram_writedata),
        .sram_byteenable(sram_byteenable), .sram_readdata(sram_readdata)
    );

    always #5 clk = ~clk;

    // Slave models: input FIFO is stim[in_rd..in_avail-1], output FIFO is out_mem[0..out_wr-1].
    logic [31:0] stim [0:255];
    logic [31:0] out_mem [0:511];
    logic [31:0] sram [0:255];
    int  in_avail = 0;
    int  in_rd = 0;
    int  out_wr = 0;
    bit  out_hold = 1'b0;
    bit  tb_flush = 1'b0;
    int  c_in_read = 0, c_out_write = 0, c_sram_wr = 0, c_done = 0, c_in_csr = 0;
    int  c_clash = 0, c_under = 0, c_over = 0, c_strobe = 0;

    always @(posedge clk) begin
        if (tb_flush) begin
            in_rd  <= 0;
            out_wr <= 0;
        end else begin
            if (in_csr_read) in_csr_readdata <= 32'(in_avail - in_rd);
            if (in_read) begin
                if (in_rd < in_avail) in_readdata <= stim[in_rd];
                else begin
                    in_readdata <= 32'hDEAD_BEEF;
                    c_under     <= c_under + 1;
                end
                in_rd <= in_rd + 1;
            end
            if (out_csr_read) out_csr_readdata <= out_hold ? 32'd256 : 32'(out_wr);
            if (out_write) begin
                if (out_wr >= 256) c_over <= c_over + 1;
                else out_mem[out_wr] <= out_writedata;
                out_wr <= out_wr + 1;
            end
        end
        if (sram_chipselect && sram_clken) begin
            if (sram_write && sram_byteenable == 4'hF) sram[sram_address] <= sram_writedata;
            else if (!sram_write) sram_readdata <= sram[sram_address];
        end
        if (in_read)                    c_in_read   <= c_in_read + 1;
        if (in_csr_read)                c_in_csr    <= c_in_csr + 1;
        if (out_write)                  c_out_write <= c_out_write + 1;
        if (sram_chipselect && sram_write) c_sram_wr <= c_sram_wr + 1;
        if (done)                       c_done      <= c_done + 1;
        if ($countones({in_csr_read, in_read, out_csr_read, out_write, sram_chipselect}) > 1)
            c_clash <= c_clash + 1;
        if (in_csr_read | in_read | out_csr_read | out_write | sram_chipselect | sram_write)
            c_strobe <= c_strobe + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic flush();
        @(negedge clk);
        tb_flush = 1'b1;
        in_avail = 0;
        out_hold = 1'b0;
        @(negedge clk);
        tb_flush = 1'b0;
    endtask

    task automatic pulse_start(input int l);
        @(negedge clk);
        len   = 9'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk(tag, {5'd0, busy, done, checksum, in_csr_read, in_read, out_csr_read, out_write,
                  sram_chipselect, sram_write, sram_clken, sram_byteenable, sram_address,
                  in_csr_address, out_csr_address}, 64'd0);
        chk({tag, "_data"}, {sram_writedata, out_writedata}, 64'd0);
    endtask

    task automatic run_xfer(input int l, input int delay, input int hold);
        logic [31:0] exp_sum;
        int s_in, s_out, s_wr, s_done, s_csr, cyc, bad_sram, bad_out;
        bit ok;
        flush();
        exp_sum = '0;
        for (int i = 0; i < l; i++) begin
            stim[i] = $urandom;
            exp_sum ^= stim[i];
        end
        s_in = c_in_read; s_out = c_out_write; s_wr = c_sram_wr; s_done = c_done; s_csr = c_in_csr;
        if (delay == 0) in_avail = l;
        out_hold = (hold > 0);
        pulse_start(l);
        chk($sformatf("busy_up_l%0d", l), 64'(busy), 64'd1);
        if (delay > 0) begin
            repeat (delay) @(negedge clk);
            chk("empty_no_read", 64'(c_in_read - s_in), 64'd0);
            chk("empty_polling", 64'((c_in_csr - s_csr) > 3), 64'd1);
            in_avail = l;
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("full_no_write", 64'(c_out_write - s_out), 64'd0);
            chk("full_busy", 64'(busy), 64'd1);
            out_hold = 1'b0;
        end
        wait_done(40 * l + 400, cyc, ok);
        chk($sformatf("done_seen_l%0d", l), 64'(ok), 64'd1);
        chk($sformatf("checksum_l%0d", l), 64'(checksum), 64'(exp_sum));
        @(negedge clk);
        chk("done_one_cycle", 64'({done, busy}), 64'd0);
        repeat (3) @(negedge clk);
        chk("checksum_hold", 64'(checksum), 64'(exp_sum));
        chk("done_count", 64'(c_done - s_done), 64'd1);
        chk("in_read_count", 64'(c_in_read - s_in), 64'(l));
        chk("sram_wr_count", 64'(c_sram_wr - s_wr), 64'(l));
        chk("out_write_count", 64'(c_out_write - s_out), 64'(l));
        bad_sram = 0;
        bad_out  = 0;
        for (int i = 0; i < l; i++) begin
            if (sram[i] !== stim[i])    bad_sram++;
            if (out_mem[i] !== stim[i]) bad_out++;
        end
        chk($sformatf("sram_data_l%0d", l), 64'(bad_sram), 64'd0);
        chk($sformatf("out_data_l%0d", l), 64'(bad_out), 64'd0);
    endtask

    initial begin
        int cyc, s_strobe, s_done;
        bit ok;

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_xfer(4, 0, 0);

        // Zero-length transfer: done two cycles after the start cycle, no bus activity.
        flush();
        s_strobe = c_strobe;
        s_done   = c_done;
        pulse_start(0);
        wait_done(20, cyc, ok);
        chk("len0_done", 64'(ok), 64'd1);
        chk("len0_latency", 64'(cyc + 1), 64'd2);
        @(negedge clk);
        chk("len0_strobes", 64'(c_strobe - s_strobe), 64'd0);
        chk("len0_done_count", 64'(c_done - s_done), 64'd1);

        run_xfer(1, 20, 0);
        run_xfer(4, 0, 60);
        run_xfer(256, 0, 0);
        for (int k = 0; k < 3; k++) run_xfer(int'($urandom_range(1, 40)), 0, 0);

        // Reset asserted while the first word is being written into SRAM.
        flush();
        for (int i = 0; i < 8; i++) stim[i] = $urandom;
        in_avail = 8;
        pulse_start(8);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sram_chipselect && sram_write) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_reached_wr", 64'(ok), 64'd1);
        s_done  = c_done;
        reset_n = 1'b0;
        #1;
        check_idle_zero("rst_async");
        @(negedge clk);
        check_idle_zero("rst_next_edge");
        repeat (3) @(negedge clk);
        chk("rst_no_done", 64'(c_done - s_done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        run_xfer(5, 0, 0);

        chk("strobe_clash", 64'(c_clash), 64'd0);
        chk("in_underflow", 64'(c_under), 64'd0);
        chk("out_overflow", 64'(c_over), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
